div_12864: RTL and testbench

- Sequential restoring divider. Divides a 128-bit dividend by a 64-bit divisor and returns a 128-bit quotient and a 64-bit remainder.
- It is the inverse of the 64x64 multiplier. Its main use is reducing a 128-bit product modulo a 64-bit RSA modulus.
- Resolves one quotient bit per clock.
- Uses the same rst_n-as-start / ready_n-as-done handshake as the other arithmetic units.

---
 rtl/div_12864_if.sv | 37 +++
 rtl/div_12864.sv | 141 ++++++++++++++
 tb/tb_div_12864.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_12864_if.sv
// div_12864_if: operand/result bundle for the 128/64 sequential divider.
//
// Signals:
//   a       [127:0]  dividend (driven by master)
//   b       [63:0]   divisor  (driven by master)
//   q       [127:0]  quotient  floor(a/b) (driven by slave)
//   r       [63:0]   remainder a mod b   (driven by slave)
//   div0             divisor was zero at load (driven by slave)
//   ready_n          low while q, r, div0 are valid (driven by slave)
//
// Modports: master = operand source / result consumer, slave = divider.
interface div_12864_if;
  logic [127:0] a;
  logic [63:0]  b;
  logic [127:0] q;
  logic [63:0]  r;
  logic         div0;
  logic         ready_n;

  modport master (
    output a,
    output b,
    input  q,
    input  r,
    input  div0,
    input  ready_n
  );

  modport slave (
    input  a,
    input  b,
    output q,
    output r,
    output div0,
    output ready_n
  );
endinterface

// File: rtl/div_12864.sv
// div_12864: sequential restoring divider, 128-bit dividend / 64-bit divisor,
// one quotient bit per clock. Used to reduce a 128-bit product modulo a
// 64-bit modulus.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; its release starts an operation
//   bus        div_12864_if.slave: a, b in; q, r, div0, ready_n out
//   dbg_state  current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//
// Handshake: there is no valid/ready pair. Releasing rst_n acts as "start":
// a and b are sampled on the first rising edge with rst_n=1 (edge 1) and are
// ignored afterwards. ready_n falling low means "done": q, r and div0 are
// valid from then on and stay constant until rst_n is asserted again.
// Asserting rst_n aborts at once and clears every output. Latency is 129
// clocks for a nonzero divisor and 2 clocks for a zero divisor.
module div_12864 (
  input  logic        clk,
  input  logic        rst_n,
  div_12864_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [127:0] d_reg;     // dividend, shifted out MSB first
  logic [63:0]  b_reg;     // latched divisor
  logic [63:0]  p_reg;     // partial remainder
  logic [127:0] q_reg;     // quotient, shifted in LSB first
  logic [6:0]   cnt;       // iteration index 0..127

  logic [127:0] q_out;
  logic [63:0]  r_out;
  logic         div0_out;
  logic         ready_n_out;

  // Iteration datapath. T needs 65 bits because the shifted remainder can
  // reach 2*B-1. When T >= B the difference is below B < 2^64, so taking it
  // modulo 2^64 is exact and the stored remainder never needs a 65th bit.
  logic [64:0]  t_val;
  logic [63:0]  diff;
  logic         q_bit;
  logic [63:0]  p_nxt;
  logic [127:0] q_shift;
  logic         last_iter;
  logic         b_zero;

  always_comb begin
    t_val     = {p_reg, d_reg[127]};
    diff      = t_val[63:0] - b_reg;
    q_bit     = (t_val >= {1'b0, b_reg});
    p_nxt     = q_bit ? diff : t_val[63:0];
    q_shift   = {q_reg[126:0], q_bit};
    last_iter = (cnt == 7'd127);
    b_zero    = (b_reg == 64'd0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. LOAD performs the first iteration (edge 2), so RUN
  // covers iterations 1..127 and exits on the one with cnt == 127.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    state_nxt = b_zero ? DONE : RUN;
      RUN:     state_nxt = last_iter ? DONE : RUN;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg       <= '0;
      b_reg       <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      cnt         <= '0;
      q_out       <= '0;
      r_out       <= '0;
      div0_out    <= 1'b0;
      ready_n_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          d_reg <= bus.a;
          b_reg <= bus.b;
          p_reg <= '0;
          q_reg <= '0;
          cnt   <= '0;
        end
        LOAD, RUN: begin
          if (state == LOAD && b_zero) begin
            // Divide by zero: saturated quotient, dividend low half as remainder.
            q_out       <= '1;
            r_out       <= d_reg[63:0];
            div0_out    <= 1'b1;
            ready_n_out <= 1'b0;
          end else begin
            d_reg <= {d_reg[126:0], 1'b0};
            p_reg <= p_nxt;
            q_reg <= q_shift;
            cnt   <= cnt + 7'd1;
            if (last_iter) begin
              q_out       <= q_shift;
              r_out       <= p_nxt;
              ready_n_out <= 1'b0;
            end
          end
        end
        default: begin
          // DONE: everything holds until the next reset pulse.
        end
      endcase
    end
  end

  assign bus.q       = q_out;
  assign bus.r       = r_out;
  assign bus.div0    = div0_out;
  assign bus.ready_n = ready_n_out;
  assign dbg_state   = state;

endmodule

// File: tb/tb_div_12864.sv
module tb_div_12864;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  div_12864_if dif ();

  div_12864 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (dif),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // item = {div0, q[127:0], r[63:0], latency[7:0]}
  localparam int W = 201;
  logic [W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit seen  = 1'b0;
  logic [127:0] hold_q;
  logic [63:0]  hold_r;
  logic         hold_div0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain arithmetic on the whole operands.
  function automatic logic [W-1:0] model(input logic [127:0] av, input logic [63:0] bv);
    logic [127:0] qm;
    logic [127:0] rm;
    if (bv == 64'd0) begin
      qm = '1;
      return {1'b1, qm, av[63:0], 8'd2};
    end
    qm = av / {64'd0, bv};
    rm = av % {64'd0, bv};
    return {1'b0, qm, rm[63:0], 8'd129};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (!rst_n) begin
      cyc  = 0;
      seen = 1'b0;
    end else begin
      cyc++;
      if (!seen) begin
        if (dif.ready_n == 1'b0) begin
          seen = 1'b1;
          hold_q    = dif.q;
          hold_r    = dif.r;
          hold_div0 = dif.div0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done got=ready_n_low want=no_result (t=%0t)", $time);
          end else begin
            item = exp_q.pop_front();
            check("done_q",    dif.q,                item[199:72]);
            check("done_r",    {64'd0, dif.r},       {64'd0, item[71:8]});
            check("done_div0", {127'd0, dif.div0},   {127'd0, item[200]});
            check("latency",   128'(cyc),            {120'd0, item[7:0]});
          end
        end else begin
          check("busy_outputs", {dif.q[127:66], dif.div0, dif.r, 1'b0}, 128'd0);
        end
      end else begin
        check("hold_ready_n", {127'd0, dif.ready_n}, 128'd0);
        check("hold_q", dif.q, hold_q);
        check("hold_r_div0", {63'd0, dif.div0, dif.r}, {63'd0, hold_div0, hold_r});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [127:0] av, input logic [63:0] bv,
                        input bit directed, input logic [127:0] eq, input logic [63:0] er,
                        input int abort_at, input int change_at, input int hold);
    logic [W-1:0] item;
    bit finished;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    dif.a = av;
    dif.b = bv;
    @(negedge clk);
    #1;
    item = model(av, bv);
    if (directed) begin
      item[199:72] = eq;
      item[71:8]   = er;
    end
    if (abort_at < 0) exp_q.push_back(item);
    rst_n = 1'b1;
    finished = 1'b0;
    for (int k = 1; k <= 140 && !finished; k++) begin
      @(negedge clk);
      #2;
      if (k == change_at) begin
        dif.a = {$urandom, $urandom, $urandom, $urandom};
        dif.b = {$urandom, $urandom} | 64'd1;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_ready_n", {127'd0, dif.ready_n}, 128'd1);
        check("abort_q", dif.q, 128'd0);
        check("abort_r_div0", {63'd0, dif.div0, dif.r}, 128'd0);
        check("abort_state", {126'd0, dbg_state}, 128'd0);
        finished = 1'b1;
      end
      if (abort_at < 0 && exp_q.size() == 0) finished = 1'b1;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL timeout got=no_ready_n want=done_within_140 (t=%0t)", $time);
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] prod;
    logic [127:0] ra;
    logic [63:0]  rb;
    int sel;

    rst_n = 1'b0;
    dif.a = '0;
    dif.b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_q", dif.q, 128'd0);
    check("reset_r_div0", {63'd0, dif.div0, dif.r}, 128'd0);
    check("reset_ready_n", {127'd0, dif.ready_n}, 128'd1);
    check("reset_state", {126'd0, dbg_state}, 128'd0);

    // trivial, then a long hold
    run_op(128'd1, 64'd1, 1'b1, 128'd1, 64'd0, -1, -1, 200);
    // multiplier round trip
    prod = 128'h0000_0000_0000_0000_0000_ed91_f81f_da13 * 128'h0000_0000_0000_0000_0000_d91a_e301_dedd;
    run_op(prod, 64'hd91ae301dedd, 1'b1, 128'hed91f81fda13, 64'd0, -1, -1, 3);
    run_op(prod + 128'd5, 64'hd91ae301dedd, 1'b1, 128'hed91f81fda13, 64'd5, -1, -1, 3);
    // max width and small dividend
    run_op('1, '1, 1'b1, 128'h0000_0000_0000_0001_0000_0000_0000_0001, 64'd0, -1, -1, 3);
    run_op(128'd5, 64'd9, 1'b1, 128'd0, 64'd5, -1, -1, 3);
    // divide by zero
    run_op(128'h1234, 64'd0, 1'b1, '1, 64'h1234, -1, -1, 10);
    // abort at clock 60 of RUN, then a fresh operation
    run_op(128'd1 << 100, 64'd3, 1'b0, 128'd0, 64'd0, 61, -1, 2);
    run_op(128'd100, 64'd7, 1'b1, 128'd14, 64'd2, -1, -1, 3);
    // operands changed at clock 5 of RUN
    run_op(128'd1000, 64'd10, 1'b1, 128'd100, 64'd0, -1, 6, 3);

    // randomized operations against the model
    for (int i = 0; i < 16; i++) begin
      ra  = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        0:       rb = 64'($urandom_range(1, 255));
        1:       rb = 64'd0;
        2:       begin rb = {$urandom, $urandom}; ra = {64'd0, ra[63:0]}; end
        3:       rb = {32'd0, $urandom} | 64'd1;
        default: rb = {$urandom, $urandom};
      endcase
      run_op(ra, rb, 1'b0, 128'd0, 64'd0, -1, -1, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
